// File: rtl/multicycle_controller.sv
// multicycle_controller: main control unit for a multicycle RV32I core.
// A Moore FSM sequences fetch, decode, execute, memory and writeback.
// It decodes lw, sw, R-type, I-type ALU, beq and jal.
//
// Ports:
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset; loads FETCH
//   op_i          instr[6:0]
//   funct3_i      instr[14:12]
//   funct7b5_i    instr[30]
//   zero_i        ALU zero flag; only used in BEQ
//   pcwrite_o     PC register enable
//   adrsrc_o      memory address select (0 PC, 1 ALUOut)
//   memwrite_o    data memory write enable
//   irwrite_o     instruction register / OldPC enable
//   resultsrc_o   result select (00 ALUOut, 01 Data, 10 ALUResult)
//   alusrca_o     ALU A select (00 PC, 01 OldPC, 10 rs1)
//   alusrcb_o     ALU B select (00 rs2, 01 immext, 10 constant 4)
//   immsrc_o      immediate format (00 I, 01 S, 10 B, 11 J)
//   regwrite_o    register file write enable
//   alucontrol_o  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
module multicycle_controller (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pcwrite_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] immsrc_o,
  output logic       regwrite_o,
  output logic [2:0] alucontrol_o
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBeq      = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic [3:0] out_state;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StFetch;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecR;
          OpItype:    state_d = StExecI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    state_d = StFetch;
        endcase
      end
      // lw and sw differ only in op[5]
      StMemAdr:  state_d = op_i[5] ? StMemWrite : StMemRead;
      StMemRead: state_d = StMemWb;
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StJal:     state_d = StAluWb;
      default:   state_d = StFetch;
    endcase
  end

  // During reset the outputs show FETCH values with all write enables masked.
  assign out_state = reset_i ? StFetch : state_q;

  always_comb begin
    adrsrc_o     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    resultsrc_o  = 2'b00;
    alusrca_o    = 2'b00;
    alusrcb_o    = 2'b00;
    regwrite_raw = 1'b0;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    case (out_state)
      StFetch: begin
        irwrite_raw = 1'b1;
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        pcupdate    = 1'b1;
      end
      StDecode: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
      end
      StMemAdr: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      StMemRead: adrsrc_o = 1'b1;
      StMemWb: begin
        resultsrc_o  = 2'b01;
        regwrite_raw = 1'b1;
      end
      StMemWrite: begin
        adrsrc_o     = 1'b1;
        memwrite_raw = 1'b1;
      end
      StExecR: begin
        alusrca_o = 2'b10;
        aluop     = 2'b10;
      end
      StExecI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop     = 2'b10;
      end
      StAluWb: regwrite_raw = 1'b1;
      StBeq: begin
        alusrca_o = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      StJal: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcupdate  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite_o  = (pcupdate | (branch & zero_i)) & ~reset_i;
  assign memwrite_o = memwrite_raw & ~reset_i;
  assign irwrite_o  = irwrite_raw & ~reset_i;
  assign regwrite_o = regwrite_raw & ~reset_i;

  always_comb begin
    case (op_i)
      OpLw, OpItype: immsrc_o = 2'b00;
      OpSw:          immsrc_o = 2'b01;
      OpBeq:         immsrc_o = 2'b10;
      OpJal:         immsrc_o = 2'b11;
      default:       immsrc_o = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol_o = 3'b000;
    case (aluop)
      2'b01: alucontrol_o = 3'b001;
      2'b10: begin
        case (funct3_i)
          // op[5] separates R-type sub from addi
          3'b000:  alucontrol_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alucontrol_o = 3'b101;
          3'b110:  alucontrol_o = 3'b011;
          3'b111:  alucontrol_o = 3'b010;
          default: alucontrol_o = 3'b000;
        endcase
      end
      default: alucontrol_o = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int tests = 0;
  int fails = 0;

  multicycle_controller dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .op_i         (op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .zero_i       (zero),
    .pcwrite_o    (pcwrite),
    .adrsrc_o     (adrsrc),
    .memwrite_o   (memwrite),
    .irwrite_o    (irwrite),
    .resultsrc_o  (resultsrc),
    .alusrca_o    (alusrca),
    .alusrcb_o    (alusrcb),
    .immsrc_o     (immsrc),
    .regwrite_o   (regwrite),
    .alucontrol_o (alucontrol)
  );

  always #5 clk = ~clk;

  // {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, immsrc, regwrite, alucontrol}
  logic [15:0] obs;
  assign obs = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, immsrc,
                regwrite, alucontrol};

  function automatic logic [15:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic rw,
                                     input logic [2:0] alu);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    tick();
    tick();
    chk("reset_hold", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));

    // lw
    @(negedge clk); reset = 1'b0; #1;
    chk("lw_fetch",   ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    tick(); chk("lw_decode",  ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
    tick(); chk("lw_memadr",  ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
    tick(); chk("lw_memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
    tick(); chk("lw_memwb",   ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000));

    // sw
    tick(); op = 7'b0100011; #1;
    chk("sw_fetch",    ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 0, 3'b000));
    tick(); chk("sw_decode",   ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 0, 3'b000));
    tick(); chk("sw_memadr",   ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000));
    tick(); chk("sw_memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));

    // R-type add
    tick(); op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; #1;
    chk("radd_fetch", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    tick(); chk("radd_decode", ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
    tick(); chk("radd_exec",   ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b000));
    tick(); chk("radd_aluwb",  ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));

    // R-type sub
    tick(); funct7b5 = 1'b1; tick(); tick();
    chk("rsub_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001));
    tick(); chk("rsub_aluwb", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));

    // R-type slt
    tick(); funct3 = 3'b010; funct7b5 = 1'b0; tick(); tick();
    chk("rslt_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b101));
    tick();

    // R-type or
    tick(); funct3 = 3'b110; tick(); tick();
    chk("ror_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b011));
    tick();

    // R-type and
    tick(); funct3 = 3'b111; tick(); tick();
    chk("rand_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b010));
    tick();

    // addi with funct7b5 set must still add
    tick(); op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; tick(); tick();
    chk("addi_exec", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
    tick(); chk("addi_aluwb", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));

    // beq taken
    tick(); op = 7'b1100011; funct7b5 = 1'b0; zero = 1'b1; #1;
    chk("beqt_fetch", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));
    tick(); chk("beqt_decode", ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000));
    tick(); chk("beqt_beq",    ev(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001));
    tick(); chk("beqt_back",   ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));

    // beq not taken
    zero = 1'b0;
    tick(); tick(); chk("beqn_beq", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001));
    tick(); chk("beqn_back", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));

    // jal
    op = 7'b1101111; #1;
    chk("jal_fetch", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 0, 3'b000));
    tick(); chk("jal_decode", ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 0, 3'b000));
    tick(); chk("jal_jal",    ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000));
    tick(); chk("jal_aluwb",  ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000));

    // illegal op: two cycles, no writes
    tick(); op = 7'b1111111; #1;
    chk("ill_fetch",  ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    tick(); chk("ill_decode", ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
    tick(); chk("ill_back",   ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));

    // lw aborted by reset during MEMREAD
    op = 7'b0000011; funct3 = 3'b010;
    tick(); tick();
    tick(); chk("abort_memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
    reset = 1'b1; #1;
    chk("abort_rst_comb", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    tick(); chk("abort_rst_edge", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    reset = 1'b0; #1;
    chk("abort_refetch", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
    tick(); chk("abort_decode", ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
